// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// programmable almost flags, exact occupancy and registered overflow/underflow pulses.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 16,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          w_en,
    input  logic                          r_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DATA_DEPTH):0]   data_num,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DATA_DEPTH);

    if ((DATA_DEPTH < 2) || ((DATA_DEPTH & (DATA_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flex: DATA_DEPTH must be a power of 2 and at least 2");
    end
    if (AFULL_THRESH > DATA_DEPTH) begin : g_bad_afull
        $error("sync_fifo_flex: AFULL_THRESH must not exceed DATA_DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW-1:0]         rd_idx;
    logic                  rd_acc;
    logic                  wr_acc;

    // Wrap bit makes the modular difference distinguish full from empty.
    assign data_num     = wr_ptr - rd_ptr;
    assign full         = (data_num == DEPTH_N);
    assign empty        = (data_num == '0);
    assign almost_full  = (32'(data_num) >= AFULL_THRESH);
    assign almost_empty = (32'(data_num) <= AEMPTY_THRESH);
    assign rd_idx       = rd_ptr[AW-1:0];

    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            overflow  <= w_en & ~wr_acc;
            underflow <= r_en & ~rd_acc;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_idx];
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_idx];
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three configurations share one stimulus stream and are
// scored each cycle against a shift-array queue model, plus directed table and sequences.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout4, dout16, dout8;
    logic [2:0] num4;
    logic [4:0] num16;
    logic [3:0] num8;
    logic       full4, empty4, af4, ae4, ovf4, unf4;
    logic       full16, empty16, af16, ae16, ovf16, unf16;
    logic       full8, empty8, af8, ae8, ovf8, unf8;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .DATA_DEPTH(4), .FWFT(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
        .data_out(dout4), .full(full4), .empty(empty4), .almost_full(af4),
        .almost_empty(ae4), .data_num(num4), .overflow(ovf4), .underflow(unf4)
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DATA_DEPTH(16), .FWFT(1'b1), .AFULL_THRESH(14),
                     .AEMPTY_THRESH(2)) u_d16 (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
        .data_out(dout16), .full(full16), .empty(empty16), .almost_full(af16),
        .almost_empty(ae16), .data_num(num16), .overflow(ovf16), .underflow(unf16)
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DATA_DEPTH(8), .FWFT(1'b0), .AFULL_THRESH(6),
                     .AEMPTY_THRESH(2)) u_d8 (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
        .data_out(dout8), .full(full8), .empty(empty8), .almost_full(af8),
        .almost_empty(ae8), .data_num(num8), .overflow(ovf8), .underflow(unf8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Reference: occupancy-ordered array, index 0 is always the oldest word.
    int         dep [3] = '{4, 16, 8};
    bit         fw  [3] = '{1'b0, 1'b1, 1'b0};
    int         aft [3] = '{2, 14, 6};
    int         aet [3] = '{2, 2, 2};
    string      pfx [3] = '{"d4", "d16", "d8"};
    logic [7:0] mq  [3][16];
    int         mcnt[3];
    logic [7:0] mdout[3];
    bit         movf[3];
    bit         munf[3];

    typedef struct {
        bit         rst;
        bit         w;
        bit         r;
        logic [7:0] d;
        int         num;
        bit         full;
        bit         empty;
        bit         ovf;
        bit         unf;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit rd, wr;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mcnt[i] = 0; mdout[i] = '0; movf[i] = 1'b0; munf[i] = 1'b0;
            end else begin
                rd = r_en && (mcnt[i] > 0);
                wr = w_en && ((mcnt[i] < dep[i]) || rd);
                movf[i] = w_en && !wr;
                munf[i] = r_en && !rd;
                if (rd) begin
                    if (!fw[i]) mdout[i] = mq[i][0];
                    for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                    mcnt[i]--;
                end
                if (wr) begin
                    mq[i][mcnt[i]] = data_in;
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [7:0] dout, input logic [31:0] num,
                              input logic full, input logic empty, input logic af,
                              input logic ae, input logic ovf, input logic unf);
        logic [7:0] exp_dout;
        if (fw[i]) exp_dout = (mcnt[i] == 0) ? 8'h00 : mq[i][0];
        else       exp_dout = mdout[i];
        chk({pfx[i], ".data_out"},     32'(dout),  32'(exp_dout));
        chk({pfx[i], ".data_num"},     num,        32'(mcnt[i]));
        chk({pfx[i], ".full"},         32'(full),  32'(mcnt[i] == dep[i]));
        chk({pfx[i], ".empty"},        32'(empty), 32'(mcnt[i] == 0));
        chk({pfx[i], ".almost_full"},  32'(af),    32'(mcnt[i] >= aft[i]));
        chk({pfx[i], ".almost_empty"}, 32'(ae),    32'(mcnt[i] <= aet[i]));
        chk({pfx[i], ".overflow"},     32'(ovf),   32'(movf[i]));
        chk({pfx[i], ".underflow"},    32'(unf),   32'(munf[i]));
    endtask

    // One clock: advance the model on the edge, compare every instance 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        if (rst) checking = 1'b1;
        #1;
        if (checking) begin
            check_inst(0, dout4,  32'(num4),  full4,  empty4,  af4,  ae4,  ovf4,  unf4);
            check_inst(1, dout16, 32'(num16), full16, empty16, af16, ae16, ovf16, unf16);
            check_inst(2, dout8,  32'(num8),  full8,  empty8,  af8,  ae8,  ovf8,  unf8);
        end
    endtask

    task automatic idle();
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        int wp, rp;

        // rst, w, r, data, num, full, empty, ovf, unf, data_out  (DEPTH=4 registered read)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h44, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h55, 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h44, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h55, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};

        for (int k = 0; k < 22; k++) begin
            rst = tbl[k].rst; w_en = tbl[k].w; r_en = tbl[k].r; data_in = tbl[k].d;
            tick();
            chk($sformatf("row%0d.data_num", k),  32'(num4),   32'(tbl[k].num));
            chk($sformatf("row%0d.full", k),      32'(full4),  32'(tbl[k].full));
            chk($sformatf("row%0d.empty", k),     32'(empty4), 32'(tbl[k].empty));
            chk($sformatf("row%0d.overflow", k),  32'(ovf4),   32'(tbl[k].ovf));
            chk($sformatf("row%0d.underflow", k), 32'(unf4),   32'(tbl[k].unf));
            chk($sformatf("row%0d.data_out", k),  32'(dout4),  32'(tbl[k].dout));
        end
        idle();

        // FWFT: a word written into an empty FIFO is visible without r_en
        rst = 1'b1; tick(); idle();
        w_en = 1'b1; data_in = 8'hA5; tick(); idle();
        chk("fwft.empty", 32'(empty16), 32'(0));
        chk("fwft.data_out", 32'(dout16), 32'h0000_00A5);
        tick();
        chk("fwft.hold", 32'(dout16), 32'h0000_00A5);
        r_en = 1'b1; tick(); idle();
        chk("fwft.pop_empty", 32'(empty16), 32'(1));
        chk("fwft.pop_data", 32'(dout16), 32'(0));

        // Threshold crossing on DEPTH=16, AFULL=14, AEMPTY=2
        rst = 1'b1; tick(); idle();
        chk("thr.af0", 32'(af16), 32'(0));
        chk("thr.ae0", 32'(ae16), 32'(1));
        for (int k = 1; k <= 16; k++) begin
            w_en = 1'b1; data_in = 8'(k); tick();
            chk($sformatf("thr.num%0d", k), 32'(num16), 32'(k));
            chk($sformatf("thr.af%0d", k),  32'(af16),  32'(k >= 14));
            chk($sformatf("thr.ae%0d", k),  32'(ae16),  32'(k <= 2));
        end
        tick();
        chk("thr.overflow", 32'(ovf16), 32'(1));
        idle();

        // Randomised traffic, phased to hit full, empty and pointer wrap
        rst = 1'b1; tick(); idle();
        for (int n = 0; n < 360; n++) begin
            if (n < 120)      begin wp = 80; rp = 30; end
            else if (n < 240) begin wp = 30; rp = 80; end
            else              begin wp = 60; rp = 60; end
            w_en    = ($urandom_range(0, 99) < wp);
            r_en    = ($urandom_range(0, 99) < rp);
            data_in = 8'($urandom);
            tick();
        end
        idle();

        // Reset with five words queued, alongside live w_en/r_en
        rst = 1'b1; tick(); idle();
        for (int k = 0; k < 5; k++) begin
            w_en = 1'b1; data_in = 8'(8'hC0 + k); tick();
        end
        idle(); r_en = 1'b1; tick(); idle();
        w_en = 1'b1; data_in = 8'hC5; tick(); idle();
        chk("mid.num_before", 32'(num8), 32'(5));
        rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE; tick(); idle();
        chk("mid.empty", 32'(empty8), 32'(1));
        chk("mid.data_num", 32'(num8), 32'(0));
        chk("mid.data_out", 32'(dout8), 32'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
